// File: rtl/board_io_conditioner.sv
// Board input front end: synchronise, debounce and edge-detect switch lines,
// and sequence the system reset from the clock generator lock signal.
module board_io_conditioner #(
  parameter int NumIn           = 8,
  parameter int SyncStages      = 2,
  parameter int DebounceCycles  = 500000,
  parameter int ResetHoldCycles = 16
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic             locked_i,
  input  logic [NumIn-1:0] gp_raw_i,
  output logic             rst_out_no,
  output logic [NumIn-1:0] gp_o,
  output logic [NumIn-1:0] rise_o,
  output logic [NumIn-1:0] fall_o
);

  localparam int CntW =
    (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int RstW = $clog2(ResetHoldCycles + 1);

  localparam logic [CntW-1:0] CntMax =
    CntW'(DebounceCycles - 1);
  localparam logic [RstW-1:0] RstMax =
    RstW'(ResetHoldCycles - 1);

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [NumIn-1:0]      gp_sync_q [SyncStages];
  logic [SyncStages-1:0] lock_sync_q;

  logic [NumIn-1:0] s;
  logic             lock_s;

  logic [CntW-1:0]  cnt_q [NumIn];
  logic [CntW-1:0]  cnt_d [NumIn];
  logic [NumIn-1:0] gp_q, gp_d;
  logic [NumIn-1:0] rise_q, rise_d;
  logic [NumIn-1:0] fall_q, fall_d;

  logic [1:0]      state_q, state_d;
  logic [RstW-1:0] rcnt_q, rcnt_d;
  logic            rst_out_q, rst_out_d;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int k = 0; k < SyncStages; k++) begin
        gp_sync_q[k] <= '0;
      end
      lock_sync_q <= '0;
    end else begin
      gp_sync_q[0] <= gp_raw_i;
      for (int k = 1; k < SyncStages; k++) begin
        gp_sync_q[k] <= gp_sync_q[k-1];
      end
      lock_sync_q <= {lock_sync_q[SyncStages-2:0], locked_i};
    end
  end

  assign s      = gp_sync_q[SyncStages-1];
  assign lock_s = lock_sync_q[SyncStages-1];

  // Any cycle that agrees with the stable level restarts the count.
  always_comb begin
    gp_d   = gp_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NumIn; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == gp_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]  = '0;
        gp_d[i]   = s[i];
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= '0;
      end
      gp_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      gp_q   <= gp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // The lock edge counts as the first hold cycle.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (1'b1)
      (state_q == HOLD): begin
        rcnt_d = '0;
        if (lock_s) begin
          if (ResetHoldCycles == 1) begin
            state_d = RUN;
          end else begin
            state_d = COUNT;
            rcnt_d  = RstW'(1);
          end
        end
      end
      (state_q == COUNT): begin
        if (!lock_s) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end else if (rcnt_q == RstMax) begin
          state_d = RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RstW'(1);
        end
      end
      (state_q == RUN): begin
        rcnt_d = '0;
        if (!lock_s) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = HOLD;
        rcnt_d  = '0;
      end
    endcase
  end

  assign rst_out_d = (state_d == RUN);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q   <= HOLD;
      rcnt_q    <= '0;
      rst_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign rst_out_no = rst_out_q;
  assign gp_o       = gp_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: scoreboard of expected pulse events
// plus inline reset-sequencer checks.
module tb_board_io_conditioner;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic [7:0] raw;
  logic       rst_out_n;
  logic [7:0] gp, rise, fall;

  typedef struct {
    int         at;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] gp;
  } exp_t;

  exp_t q[$];
  exp_t ev;
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   mon_en;
  logic [7:0] exp_gp, e_rise, e_fall;

  board_io_conditioner #(
    .NumIn(8),
    .SyncStages(2),
    .DebounceCycles(4),
    .ResetHoldCycles(16)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .locked_i  (locked),
    .gp_raw_i  (raw),
    .rst_out_no(rst_out_n),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      e_rise = '0;
      e_fall = '0;
      if (q.size() > 0 && q[0].at == cyc) begin
        ev     = q.pop_front();
        e_rise = ev.rise;
        e_fall = ev.fall;
        exp_gp = ev.gp;
      end
      vectors++;
      if (rise !== e_rise || fall !== e_fall || gp !== exp_gp) begin
        miscompares++;
        $display("FAIL scoreboard cyc=%0d rise=%h/%h fall=%h/%h gp=%h/%h",
                 cyc, rise, e_rise, fall, e_fall, gp, exp_gp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int lat, input logic [7:0] r,
                           input logic [7:0] f, input logic [7:0] g);
    exp_t e;
    e.at   = cyc + lat;
    e.rise = r;
    e.fall = f;
    e.gp   = g;
    q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    raw    = '0;
    #3;
    vectors++;
    if ({rst_out_n, gp, rise, fall} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_state got rst=%b gp=%h rise=%h fall=%h need 0",
               rst_out_n, gp, rise, fall);
    end
    tick();
    tick();
  endtask

  task automatic test_release_lock();
    rst_n  = 1'b1;
    exp_gp = '0;
    mon_en = 1'b1;
    repeat (3) tick();
    locked = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      vectors++;
      if (rst_out_n !== (n >= 18)) begin
        miscompares++;
        $display("FAIL release edge=%0d got %b need %b",
                 n, rst_out_n, n >= 18);
      end
    end
    locked = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      vectors++;
      if (rst_out_n !== (n < 3)) begin
        miscompares++;
        $display("FAIL lock_loss edge=%0d got %b need %b",
                 n, rst_out_n, n < 3);
      end
    end
  endtask

  task automatic test_clean_press();
    raw[3] = 1'b1;
    expect_at(6, 8'h08, 8'h00, 8'h08);
    repeat (10) tick();
    raw[3] = 1'b0;
    expect_at(6, 8'h00, 8'h08, 8'h00);
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    logic pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    expect_at(10, 8'h01, 8'h00, 8'h01);
    for (int k = 0; k < 8; k++) begin
      raw[0] = pat[k];
      tick();
    end
    repeat (6) tick();
    raw[0] = 1'b0;
    expect_at(6, 8'h00, 8'h01, 8'h00);
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    raw = 8'hA5;
    expect_at(6, 8'hA5, 8'h00, 8'hA5);
    repeat (10) tick();
    raw = 8'h00;
    expect_at(6, 8'h00, 8'hA5, 8'h00);
    repeat (10) tick();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL sim_drain got %0d pending need 0", q.size());
    end
  endtask

  task automatic test_mid_reset();
    locked = 1'b1;
    raw    = 8'h30;
    expect_at(6, 8'h30, 8'h00, 8'h30);
    repeat (8) tick();
    raw = 8'h3F;
    repeat (4) tick();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    vectors++;
    if ({rst_out_n, gp, rise, fall} !== 25'd0) begin
      miscompares++;
      $display("FAIL mid_reset got rst=%b gp=%h rise=%h fall=%h need 0",
               rst_out_n, gp, rise, fall);
    end
    q.delete();
    exp_gp = '0;
    tick();
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    expect_at(6, 8'h3F, 8'h00, 8'h3F);
    for (int n = 1; n <= 20; n++) begin
      tick();
      vectors++;
      if (rst_out_n !== (n >= 18)) begin
        miscompares++;
        $display("FAIL re_release edge=%0d got %b need %b",
                 n, rst_out_n, n >= 18);
      end
    end
  endtask

  task automatic test_lock_glitch();
    locked = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if (rst_out_n !== (n < 3)) begin
        miscompares++;
        $display("FAIL glitch_drop edge=%0d got %b need %b",
                 n, rst_out_n, n < 3);
      end
    end
    locked = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      vectors++;
      if (rst_out_n !== (n >= 18)) begin
        miscompares++;
        $display("FAIL glitch_return edge=%0d got %b need %b",
                 n, rst_out_n, n >= 18);
      end
    end
  endtask

  task automatic test_back_to_back();
    raw = 8'h00;
    expect_at(6, 8'h00, 8'h3F, 8'h00);
    repeat (10) tick();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain got %0d pending need 0", q.size());
    end
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    exp_gp      = '0;
    test_reset();
    test_release_lock();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
    test_lock_glitch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
